// File: rtl/tgif_key_sched_ctrl.sv
// Tweakey register sequencer: LOAD -> ROUND x ROUNDS -> SHIFT x SHIFT_CYCLES -> DONE,
// plus round counter and SKINNY 6-bit round-constant LFSR.
module tgif_key_sched_ctrl #(
  parameter int ROUNDS       = 40,
  parameter int SHIFT_CYCLES = 4,
  parameter int CNT_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             key_enc,
  output logic             key_se,
  output logic             key_ld,
  output logic [CNT_W-1:0] round_cnt,
  output logic [5:0]       rc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_SHIFT, S_DONE} state_e;

  localparam logic [CNT_W-1:0] LAST_RND  = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] LAST_SHF  = CNT_W'((SHIFT_CYCLES > 0) ? SHIFT_CYCLES - 1 : 0);
  localparam bit               HAS_SHIFT = (SHIFT_CYCLES > 0);
  localparam logic [5:0]       RC_INIT   = 6'h01;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [5:0]       rc_q, rc_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      round_cnt_q <= '0;
      shift_cnt_q <= '0;
      rc_q        <= RC_INIT;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      rc_q        <= rc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    shift_cnt_d = shift_cnt_q;
    rc_d        = rc_q;
    case (state_q)
      S_IDLE: begin
        round_cnt_d = '0;
        shift_cnt_d = '0;
        rc_d        = RC_INIT;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!stall) begin
          state_d     = S_ROUND;
          round_cnt_d = '0;
          rc_d        = RC_INIT;
        end
      end
      S_ROUND: begin
        if (!stall) begin
          if (round_cnt_q == LAST_RND) begin
            // counters park at their idle values so the datapath sees 0/01 outside rounds
            state_d     = HAS_SHIFT ? S_SHIFT : S_DONE;
            round_cnt_d = '0;
            shift_cnt_d = '0;
            rc_d        = RC_INIT;
          end else begin
            round_cnt_d = round_cnt_q + CNT_W'(1);
            rc_d        = {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};
          end
        end
      end
      S_SHIFT: begin
        if (!stall) begin
          if (shift_cnt_q == LAST_SHF) state_d = S_DONE;
          else shift_cnt_d = shift_cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    key_enc = 1'b0;
    key_se  = 1'b0;
    key_ld  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_LOAD: begin
        key_enc = !stall;
        key_se  = 1'b1;
        key_ld  = 1'b1;
        busy    = 1'b1;
      end
      S_ROUND: begin
        key_enc = !stall;
        busy    = 1'b1;
      end
      S_SHIFT: begin
        key_enc = !stall;
        key_se  = 1'b1;
        busy    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign round_cnt = round_cnt_q;
  assign rc        = rc_q;

endmodule

// File: tb/tb_tgif_key_sched_ctrl.sv
// Bench for tgif_key_sched_ctrl: four parameterisations share stimulus, each checked
// every cycle against a run-position model; plus a vector table and directed sequences.
module tb_tgif_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst, start, stall;
  always #5 clk = ~clk;

  logic [3:0] enc, se, ld, busy, done;
  logic [5:0] cnt [4];
  logic [5:0] rcv [4];

  tgif_key_sched_ctrl #(.ROUNDS(40), .SHIFT_CYCLES(4), .CNT_W(6)) u_d0 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .key_enc(enc[0]), .key_se(se[0]),
    .key_ld(ld[0]), .round_cnt(cnt[0]), .rc(rcv[0]), .busy(busy[0]), .done(done[0]));
  tgif_key_sched_ctrl #(.ROUNDS(8), .SHIFT_CYCLES(4), .CNT_W(6)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .key_enc(enc[1]), .key_se(se[1]),
    .key_ld(ld[1]), .round_cnt(cnt[1]), .rc(rcv[1]), .busy(busy[1]), .done(done[1]));
  tgif_key_sched_ctrl #(.ROUNDS(4), .SHIFT_CYCLES(2), .CNT_W(6)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .key_enc(enc[2]), .key_se(se[2]),
    .key_ld(ld[2]), .round_cnt(cnt[2]), .rc(rcv[2]), .busy(busy[2]), .done(done[2]));
  tgif_key_sched_ctrl #(.ROUNDS(4), .SHIFT_CYCLES(0), .CNT_W(6)) u_d3 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .key_enc(enc[3]), .key_se(se[3]),
    .key_ld(ld[3]), .round_cnt(cnt[3]), .rc(rcv[3]), .busy(busy[3]), .done(done[3]));

  // Model: a run is a linear list of steps (LOAD, R rounds, S shifts, DONE); pos -1 = idle.
  int rr [4] = '{40, 8, 4, 4};
  int ss [4] = '{4, 4, 2, 0};
  int pos [4] = '{-1, -1, -1, -1};
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  function automatic logic [5:0] rc_at(int k);
    logic [5:0] r = 6'h01;
    for (int j = 0; j < k; j++) r = {r[4:0], r[5] ^ r[4] ^ 1'b1};
    return r;
  endfunction

  // {enc, se, ld, busy, done, round_cnt, rc}
  function automatic logic [16:0] exp_out(int i, logic st);
    int p = pos[i];
    int R = rr[i];
    int S = ss[i];
    logic e = 0, s_ = 0, l = 0, b = 0, d = 0;
    logic [5:0] c = 6'd0, r = 6'h01;
    if (p == 0) begin
      e = !st; s_ = 1; l = 1; b = 1;
    end else if (p >= 1 && p <= R) begin
      e = !st; b = 1; c = 6'(p - 1); r = rc_at(p - 1);
    end else if (p > R && p <= R + S) begin
      e = !st; s_ = 1; b = 1;
    end else if (p == R + S + 1) begin
      d = 1;
    end
    return {e, s_, l, b, d, c, r};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
  endtask

  task automatic apply(bit s, bit st, bit r, bit do_chk);
    start = s; stall = st; rst = r;
    #1;
    if (do_chk)
      for (int i = 0; i < 4; i++)
        chk($sformatf("model_d%0d", i),
            32'({enc[i], se[i], ld[i], busy[i], done[i], cnt[i], rcv[i]}), 32'(exp_out(i, st)));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!rst) pos[i] = -1;
      else if (pos[i] == -1) pos[i] = start ? 0 : -1;
      else if (pos[i] == rr[i] + ss[i] + 1) pos[i] = -1;
      else if (!stall) pos[i]++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(bit do_chk);
    apply(0, 0, 0, do_chk);
    tick();
    cyc = 0;
  endtask

  typedef struct {
    bit start, stall;
    bit enc, se, ld, busy, done;
    logic [5:0] cnt, rc;
  } vec_t;

  vec_t tbl [13];
  int first_done [4];
  logic [5:0] rc_seen [8];
  logic [5:0] rc_ref [8];
  bit se_again, found;
  int last_done, loads;

  initial begin
    // ROUNDS=4, SHIFT=2 instance, 3-cycle stall at round_cnt 2; start sampled at index 0
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 6'd0, 6'h01};
    tbl[1]  = '{0, 0, 1, 1, 1, 1, 0, 6'd0, 6'h01};
    tbl[2]  = '{0, 0, 1, 0, 0, 1, 0, 6'd0, 6'h01};
    tbl[3]  = '{0, 0, 1, 0, 0, 1, 0, 6'd1, 6'h03};
    tbl[4]  = '{0, 1, 0, 0, 0, 1, 0, 6'd2, 6'h07};
    tbl[5]  = '{0, 1, 0, 0, 0, 1, 0, 6'd2, 6'h07};
    tbl[6]  = '{0, 1, 0, 0, 0, 1, 0, 6'd2, 6'h07};
    tbl[7]  = '{0, 0, 1, 0, 0, 1, 0, 6'd2, 6'h07};
    tbl[8]  = '{0, 0, 1, 0, 0, 1, 0, 6'd3, 6'h0F};
    tbl[9]  = '{0, 0, 1, 1, 0, 1, 0, 6'd0, 6'h01};
    tbl[10] = '{0, 0, 1, 1, 0, 1, 0, 6'd0, 6'h01};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 6'd0, 6'h01};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 6'd0, 6'h01};
    rc_ref = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B};

    start = 0; stall = 0; rst = 0;
    @(negedge clk);
    do_reset(0);
    do_reset(1);

    // Vector table
    foreach (tbl[k]) begin
      apply(tbl[k].start, tbl[k].stall, 1, 1);
      chk($sformatf("tbl%0d", k),
          32'({enc[2], se[2], ld[2], busy[2], done[2], cnt[2], rcv[2]}),
          32'({tbl[k].enc, tbl[k].se, tbl[k].ld, tbl[k].busy, tbl[k].done, tbl[k].cnt, tbl[k].rc}));
      tick();
    end

    // Clean run on all instances: done timing, rc sequence, no SHIFT when SHIFT_CYCLES=0
    do_reset(1);
    first_done = '{-1, -1, -1, -1};
    se_again = 0;
    foreach (rc_seen[k]) rc_seen[k] = 6'h00;
    apply(1, 0, 1, 1);
    tick();
    for (int t = 1; t < 56; t++) begin
      apply(0, 0, 1, 1);
      for (int i = 0; i < 4; i++)
        if (done[i] && first_done[i] < 0) first_done[i] = cyc;
      if (busy[1] && !se[1] && cnt[1] < 8) rc_seen[cnt[1][2:0]] = rcv[1];
      if (se[3] && cyc > 1) se_again = 1;
      tick();
    end
    chk("done_cyc_r40_s4", 32'(first_done[0]), 32'd46);
    chk("done_cyc_r8_s4", 32'(first_done[1]), 32'd14);
    chk("done_cyc_r4_s2", 32'(first_done[2]), 32'd8);
    chk("done_cyc_r4_s0", 32'(first_done[3]), 32'd6);
    chk("se_after_load_s0", 32'(se_again), 32'd0);
    foreach (rc_seen[k]) chk($sformatf("rc_round%0d", k), 32'(rc_seen[k]), 32'(rc_ref[k]));
    chk("r8_idle_cnt_rc", 32'({cnt[1], rcv[1]}), 32'({6'd0, 6'h01}));

    // Reset mid-ROUND at round_cnt 5 with a coincident start, then a clean rerun
    do_reset(1);
    apply(1, 0, 1, 1);
    tick();
    found = 0;
    for (int t = 0; t < 20; t++) begin
      apply(0, 0, 1, 1);
      if (busy[0] && !se[0] && cnt[0] == 6'd5) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("reach_round5", 32'(found), 32'd1);
    apply(1, 0, 0, 1);
    tick();
    apply(0, 0, 1, 1);
    chk("post_rst_idle", 32'({enc[0], se[0], ld[0], busy[0], done[0], cnt[0], rcv[0]}),
        32'({5'b0, 6'd0, 6'h01}));
    tick();
    cyc = 0;
    first_done[0] = -1;
    apply(1, 0, 1, 1);
    tick();
    for (int t = 1; t < 50; t++) begin
      apply(0, 0, 1, 1);
      if (done[0] && first_done[0] < 0) first_done[0] = cyc;
      tick();
    end
    chk("rerun_done_cyc", 32'(first_done[0]), 32'd46);

    // start held high: back-to-back runs with one IDLE cycle between DONE and LOAD
    do_reset(1);
    last_done = -1;
    loads = 0;
    for (int t = 0; t < 80; t++) begin
      apply(1, 0, 1, 1);
      if (done[3]) last_done = cyc;
      if (ld[3]) begin
        loads++;
        if (last_done >= 0) chk("gap_done_load", 32'(cyc - last_done), 32'd2);
      end
      tick();
    end
    chk("held_start_loads", 32'(loads), 32'd12);

    // Randomized traffic, model-checked every cycle
    do_reset(1);
    for (int t = 0; t < 1500; t++) begin
      apply($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(63) != 0, 1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
